// File: rtl/cache_access_ctrl.sv
// CPU-side front end for the direct-mapped cache: turns a valid/ready request into the
// cache's level-held interface. Optional stall counter: define CACHE_ACCESS_STALL_STATS_EN.
module cache_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [DATA_WIDTH-1:0] c_din,
  output logic                  c_we,
  output logic                  c_mem_en,
  input  logic                  c_hit,
  input  logic [DATA_WIDTH-1:0] c_dout,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
`ifdef CACHE_ACCESS_STALL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_cnt_q;
  logic             first_q;

  // c_addr/c_din/c_we double as the latched request, so the cache sees registers only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      first_q    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      c_addr     <= '0;
      c_din      <= '0;
      c_we       <= 1'b0;
      c_mem_en   <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
`ifdef CACHE_ACCESS_STALL_STATS_EN
      stall_cnt  <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            c_addr     <= req_addr;
            c_din      <= req_wdata;
            c_we       <= req_we;
            c_mem_en   <= 1'b1;
            req_ready  <= 1'b0;
            wait_cnt_q <= '0;
            first_q    <= 1'b1;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          if (first_q) begin
            first_q <= 1'b0;
            if (c_hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
          end
`ifdef CACHE_ACCESS_STALL_STATS_EN
          if (!c_hit && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
          if (c_hit) begin
            // A store commits in the cache on this same edge; only loads return data.
            if (!c_we) resp_rdata <= c_dout;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            c_mem_en   <= 1'b0;
            c_we       <= 1'b0;
            state_q    <= StResp;
          end else if (wait_cnt_q == WaitMax) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            c_mem_en   <= 1'b0;
            c_we       <= 1'b0;
            state_q    <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StResp: begin
          req_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          c_mem_en  <= 1'b0;
          c_we      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Self-checking bench for cache_access_ctrl: vector table, hand sequences, random requests
// checked against a request-level latency/counter model.
module tb_cache_access_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  c_addr;
  logic [31:0] c_din;
  logic        c_we, c_mem_en, c_hit;
  logic [31:0] c_dout;
  logic [15:0] hit_cnt, miss_cnt;
`ifdef CACHE_ACCESS_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  cache_access_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT(TO), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .c_addr(c_addr), .c_din(c_din), .c_we(c_we), .c_mem_en(c_mem_en),
    .c_hit(c_hit), .c_dout(c_dout),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`ifdef CACHE_ACCESS_STALL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cache model: misses for miss_n enabled cycles, then hits with m_dout.
  int          miss_n = 0;
  logic [31:0] m_dout = '0;
  int          acc_cyc = 0;
  int          wr_cnt = 0;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  assign c_hit  = c_mem_en && (acc_cyc >= miss_n);
  assign c_dout = m_dout;

  always @(posedge clk) begin
    if (!c_mem_en) acc_cyc <= 0;
    else acc_cyc <= acc_cyc + 1;
    if (c_mem_en && c_hit && c_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= c_addr;
      wr_data <= c_din;
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference state at request granularity.
  logic [31:0] exp_rdata = '0;
  int          exp_hit = 0, exp_miss = 0, exp_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 16'hFFFF) ? 16'hFFFF : v;
  endfunction

  task automatic run_req(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                         input int nmiss, input logic [31:0] dout,
                         input int want_lat, input logic want_err, input string name);
    int   cyc = 0;
    int   acc = 0;
    int   wr0;
    logic got = 1'b0;
    logic hold_ok = 1'b1;
    logic err;
    logic [31:0] rd;
    int   exp_acc;
    exp_acc = (nmiss < TO) ? nmiss + 1 : TO;
    @(negedge clk);
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
    miss_n    = nmiss;
    m_dout    = dout;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    wr0       = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 10'($urandom);
    req_wdata = $urandom;
    while (!got && cyc < TO + 10) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        got = 1'b1;
        err = resp_err;
        rd  = resp_rdata;
      end else if (c_mem_en) begin
        acc++;
        if (c_addr !== addr || c_din !== wd || c_we !== we || req_ready !== 1'b0) hold_ok = 1'b0;
      end else begin
        hold_ok = 1'b0;
      end
    end
    if (!got) begin
      chk({name, "_resp_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (nmiss == 0) exp_hit = sat16(exp_hit + 1);
    else exp_miss = sat16(exp_miss + 1);
    exp_stall = sat16(exp_stall + ((nmiss < TO) ? nmiss : TO));
    if (!we && nmiss < TO) exp_rdata = dout;
    chk({name, "_latency"}, 64'(cyc), 64'(want_lat));
    chk({name, "_access_cycles"}, 64'(acc), 64'(exp_acc));
    chk({name, "_hold"}, 64'(hold_ok), 64'd1);
    chk({name, "_err"}, 64'(err), 64'(want_err));
    chk({name, "_rdata"}, 64'(rd), 64'(exp_rdata));
    chk({name, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
    chk({name, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
`ifdef CACHE_ACCESS_STALL_STATS_EN
    chk({name, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`endif
    if (we && nmiss < TO) begin
      chk({name, "_wr_count"}, 64'(wr_cnt - wr0), 64'd1);
      chk({name, "_wr_data"}, {22'd0, wr_addr, wr_data}, {22'd0, addr, wd});
    end else begin
      chk({name, "_wr_count"}, 64'(wr_cnt - wr0), 64'd0);
    end
    @(negedge clk);
    chk({name, "_pulse_end"}, {62'd0, resp_valid, c_mem_en}, 64'd0);
    chk({name, "_idle_ready"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          nmiss;
    logic [31:0] dout;
    int          lat;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 10'h010, 32'h0,         0,    32'h1234_5678, 2,      1'b0};
    vecs[1] = '{1'b0, 10'h3F8, 32'h0,         20,   32'hDEAD_BEEF, 22,     1'b0};
    vecs[2] = '{1'b1, 10'h005, 32'hCAFE_BABE, 8,    32'h5555_AAAA, 10,     1'b0};
    vecs[3] = '{1'b0, 10'h123, 32'h0,         1000, 32'h7777_7777, TO + 1, 1'b1};
    vecs[4] = '{1'b1, 10'h0FF, 32'h0BAD_F00D, 0,    32'h1111_2222, 2,      1'b0};
    vecs[5] = '{1'b0, 10'h2C3, 32'h0,         TO-1, 32'hFACE_0FF1, TO + 1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_resp", {61'd0, resp_valid, resp_err, c_we}, 64'd0);
    chk("reset_rdata", 64'(resp_rdata), 64'd0);
    chk("reset_cache_if", {21'd0, c_mem_en, c_addr, c_din}, 64'd0);
    chk("reset_counters", {32'd0, hit_cnt, miss_cnt}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].nmiss, vecs[i].dout,
              vecs[i].lat, vecs[i].err, $sformatf("vec%0d", i));

    // Reset in the fifth ACCESS cycle of a long miss drops the request silently.
    @(negedge clk);
    miss_n = 1000; req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h2AA; req_wdata = 32'h600D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_pre_en", 64'(c_mem_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_en", {62'd0, c_mem_en, c_we}, 64'd0);
    chk("midrst_counters", {32'd0, hit_cnt, miss_cnt}, 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    exp_hit = 0; exp_miss = 0; exp_stall = 0; exp_rdata = '0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (resp_valid || c_mem_en) seen = 1'b1;
      end
      chk("midrst_no_resp", 64'(seen), 64'd0);
    end

    for (int i = 0; i < 20; i++) begin
      int r, n, lat;
      logic w;
      r = int'($urandom_range(0, 9));
      if (r < 4) n = 0;
      else if (r < 9) n = int'($urandom_range(1, 30));
      else n = int'($urandom_range(TO, TO + 20));
      w = 1'($urandom);
      lat = (n < TO) ? n + 2 : TO + 1;
      run_req(w, 10'($urandom), $urandom, n, $urandom, lat, (n >= TO),
              $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Saturation: preload hit_cnt at all-ones, then a hitting load must not wrap.
    @(negedge clk);
    force dut.hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt;
    @(negedge clk);
    chk("sat_preload", 64'(hit_cnt), 64'hFFFF);
    exp_hit = 16'hFFFF;
    run_req(1'b0, 10'h040, 32'h0, 0, 32'h0A0B_0C0D, 2, 1'b0, "sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_access_ctrl.md
Name: cache_access_ctrl

Overview:
- CPU-side front end sitting directly upstream of the direct-mapped cache; converts a single-cycle valid/ready load/store request into the cache's level-held interface.
- Latches the request and holds addr/din/we/mem_en stable for the whole miss/refill/write-back sequence until the cache reports hit.
- Returns read data with a one-cycle response pulse and flags a refill that exceeds a timeout.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 10, word address width; must match the cache.
- TIMEOUT, 64, max cycles in ACCESS before error.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load data; stable until the next resp_valid.
- resp_err  out  1  valid with resp_valid; 1 = timeout.
- c_addr  out  ADDR_WIDTH  to cache addr.
- c_din  out  DATA_WIDTH  to cache din.
- c_we  out  1  to cache we.
- c_mem_en  out  1  to cache mem_en.
- c_hit  in  1  from cache hit (combinational).
- c_dout  in  DATA_WIDTH  from cache dout (combinational).
- hit_cnt  out  CNT_WIDTH  requests that hit on first lookup.
- miss_cnt  out  CNT_WIDTH  requests that missed on first lookup.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. Single clock domain.
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE. req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0. c_mem_en=0, c_we=0, c_addr=0, c_din=0. Counters and the wait counter reset to 0.
- IDLE:
  - req_ready=1, c_mem_en=0.
  - On req_valid: latch addr/we/wdata, clear wait_cnt, set first=1, go to ACCESS.
- ACCESS:
  - req_ready=0, c_mem_en=1.
  - c_addr, c_din and c_we come from the latched request and stay constant for every ACCESS cycle.
  - c_we may stay high during a miss; the cache only commits a write when mem_en&hit&we.
  - In the first ACCESS cycle (first=1), increment hit_cnt if c_hit=1, else miss_cnt. Exactly one count per request. first then clears.
  - c_hit=1: latch c_dout into resp_rdata on loads only (stores leave resp_rdata unchanged). The store commits in the cache on the same edge. Go to RESP, err=0.
  - c_hit=0: wait_cnt++. If wait_cnt reaches TIMEOUT-1, go to RESP with err=1 and leave resp_rdata unchanged.
- RESP:
  - resp_valid=1 and resp_err=err for exactly one cycle.
  - c_mem_en=0, c_we=0, req_ready=0; go to IDLE.
  - Deasserting mem_en clears the cache's internal write-back state.
- Latency, accept edge to resp_valid:
  - Hit: 2 cycles (accept, one ACCESS cycle, then RESP).
  - Miss: 2 + refill cycles.
  - Back-to-back throughput: one request per 3 cycles minimum.
- Counters saturate at all-ones; no wrap.
- req_valid while not ready is ignored. The CPU holds the request until it sees req_ready, and req_valid&req_ready is sampled only in IDLE.
- Reset mid-ACCESS: next cycle c_mem_en=0 and the request is dropped with no response. A partial cache refill is abandoned, and the cache line stays as the cache left it.
- No combinational path from req_* to c_*. c_hit feeds only next-state logic and the registered response.

Optional Feature:
- Macro CACHE_ACCESS_STALL_STATS_EN.
- Defined: adds output stall_cnt [CNT_WIDTH-1:0]. It counts every ACCESS cycle with c_hit=0, saturates at all-ones, and resets to 0.
- Not defined: no port and no logic; hit_cnt/miss_cnt are unaffected.

Test Plan:
- Reset, then a load to 0x010 with the cache model hitting immediately and c_dout=0x1234_5678 -> resp_valid 2 cycles after accept, resp_rdata=0x12345678, resp_err=0, hit_cnt=1, miss_cnt=0.
- Load to 0x3F8 with the model missing for 20 cycles, then hit with dout=0xDEADBEEF -> c_addr=0x3F8 and c_mem_en=1 on all 21 ACCESS cycles; resp at 22 cycles after accept; miss_cnt=1; stall_cnt=20 when the macro is defined.
- Store 0xCAFEBABE to 0x005 on a miss lasting 8 cycles -> c_we=1 and c_din=0xCAFEBABE constant throughout; the model records exactly one write, at the hit edge; resp_rdata unchanged.
- Model never hits, TIMEOUT=64 -> resp_valid with resp_err=1 exactly 64 ACCESS cycles after entry; then IDLE with req_ready=1.
- Assert rst mid-miss (cycle 5 of ACCESS) -> c_mem_en=0 the next cycle, no resp_valid, counters=0, req_ready=1.
- Hold hit_cnt preloaded (force) at 0xFFFF and issue a hitting load -> hit_cnt stays 0xFFFF.
